// File: rtl/dsp_frame_scheduler_if.sv
// Frame-scheduler bus: capture side, DSPCore handshake, result side and status.
// The scheduler takes the slave view; the surrounding system takes the master view.
interface dsp_frame_scheduler_if #(
    parameter int unsigned NumCh = 8,
    parameter int unsigned Width = 24,
    parameter int unsigned OvrW  = 16
);
    localparam int unsigned BusW = NumCh * Width;

    logic            in_valid;
    logic [BusW-1:0] in_audio;
    logic            dsp_start;
    logic [BusW-1:0] dsp_inputs;
    logic            dsp_done;
    logic [BusW-1:0] dsp_outputs;
    logic [BusW-1:0] out_audio;
    logic            out_valid;
    logic            busy;
    logic            clear_status;
    logic [OvrW-1:0] overrun_count;
    logic            timeout_flag;

    modport slave (
        input  in_valid,
        input  in_audio,
        input  dsp_done,
        input  dsp_outputs,
        input  clear_status,
        output dsp_start,
        output dsp_inputs,
        output out_audio,
        output out_valid,
        output busy,
        output overrun_count,
        output timeout_flag
    );

    modport master (
        output in_valid,
        output in_audio,
        output dsp_done,
        output dsp_outputs,
        output clear_status,
        input  dsp_start,
        input  dsp_inputs,
        input  out_audio,
        input  out_valid,
        input  busy,
        input  overrun_count,
        input  timeout_flag
    );
endinterface

// File: rtl/dsp_frame_scheduler.sv
// Runs DSPCore once per ADAT frame: snapshots input, pulses start, waits for done
// under a watchdog, and holds the result bus. One-deep pending slot, overrun/timeout status.
module dsp_frame_scheduler #(
    parameter int unsigned NumCh   = 8,
    parameter int unsigned Width   = 24,
    parameter int unsigned Timeout = 2000,
    parameter int unsigned OvrW    = 16
) (
    input logic                  clk_i,
    input logic                  reset_ni,
    dsp_frame_scheduler_if.slave bus
);
    localparam int unsigned BusW = NumCh * Width;
    localparam int unsigned WdW  = $clog2(Timeout + 1);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StRun
    } state_e;

    state_e          state_q, state_d;
    logic [BusW-1:0] dsp_inputs_q, dsp_inputs_d;
    logic [BusW-1:0] pend_buf_q, pend_buf_d;
    logic            pending_q, pending_d;
    logic [BusW-1:0] out_audio_q, out_audio_d;
    logic            out_valid_q, out_valid_d;
    logic            dsp_start_q, dsp_start_d;
    logic [WdW-1:0]  watchdog_q, watchdog_d;
    logic [OvrW-1:0] overrun_q, overrun_d;
    logic            timeout_q, timeout_d;
    logic            drop;

    always_comb begin
        state_d      = state_q;
        dsp_inputs_d = dsp_inputs_q;
        pend_buf_d   = pend_buf_q;
        pending_d    = pending_q;
        out_audio_d  = out_audio_q;
        out_valid_d  = 1'b0;
        dsp_start_d  = 1'b0;
        watchdog_d   = watchdog_q;
        overrun_d    = bus.clear_status ? '0 : overrun_q;
        timeout_d    = bus.clear_status ? 1'b0 : timeout_q;
        drop         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pending_q) begin
                    // Older frame goes first; a coincident new frame refills the slot.
                    dsp_inputs_d = pend_buf_q;
                    pending_d    = 1'b0;
                    state_d      = StLaunch;
                    if (bus.in_valid) begin
                        pend_buf_d = bus.in_audio;
                        pending_d  = 1'b1;
                    end
                end else if (bus.in_valid) begin
                    dsp_inputs_d = bus.in_audio;
                    state_d      = StLaunch;
                end
            end
            StLaunch: begin
                dsp_start_d = 1'b1;
                watchdog_d  = WdW'(Timeout);
                state_d     = StRun;
            end
            StRun: begin
                if (bus.dsp_done) begin
                    out_audio_d = bus.dsp_outputs;
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end else if (watchdog_q == WdW'(1)) begin
                    out_audio_d = '0;
                    out_valid_d = 1'b1;
                    timeout_d   = 1'b1;
                    watchdog_d  = '0;
                    state_d     = StIdle;
                end else begin
                    watchdog_d = watchdog_q - WdW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && bus.in_valid) begin
            if (!pending_q) begin
                pend_buf_d = bus.in_audio;
                pending_d  = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        if (drop && overrun_d != '1) begin
            overrun_d = overrun_d + OvrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= StIdle;
            dsp_inputs_q <= '0;
            pend_buf_q   <= '0;
            pending_q    <= 1'b0;
            out_audio_q  <= '0;
            out_valid_q  <= 1'b0;
            dsp_start_q  <= 1'b0;
            watchdog_q   <= '0;
            overrun_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dsp_inputs_q <= dsp_inputs_d;
            pend_buf_q   <= pend_buf_d;
            pending_q    <= pending_d;
            out_audio_q  <= out_audio_d;
            out_valid_q  <= out_valid_d;
            dsp_start_q  <= dsp_start_d;
            watchdog_q   <= watchdog_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.dsp_start     = dsp_start_q;
    assign bus.dsp_inputs    = dsp_inputs_q;
    assign bus.out_audio     = out_audio_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.busy          = (state_q != StIdle);
    assign bus.overrun_count = overrun_q;
    assign bus.timeout_flag  = timeout_q;

endmodule

// File: tb/tb_dsp_frame_scheduler.sv
// Directed bench for dsp_frame_scheduler: launch latency, pending/overrun, watchdog,
// done-vs-expiry priority, reset abort and overrun saturation.
module tb_dsp_frame_scheduler;
    localparam int unsigned NumCh = 8;
    localparam int unsigned Width = 24;
    localparam int unsigned OvrW  = 16;
    localparam int unsigned BusW  = NumCh * Width;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    int   ov_cnt = 0;
    int   ov0;

    logic [BusW-1:0] f1, f2, f3, f4, f5, f6, f7, f8, f9, f10, f11, f12, f13, f14;
    logic [BusW-1:0] o1, o2, o3, o4, o5;

    dsp_frame_scheduler_if #(.NumCh(NumCh), .Width(Width), .OvrW(OvrW)) bus ();

    dsp_frame_scheduler #(
        .NumCh  (NumCh),
        .Width  (Width),
        .Timeout(2000),
        .OvrW   (OvrW)
    ) dut (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.out_valid === 1'b1) ov_cnt++;

    task automatic check(input string tag, input logic [BusW-1:0] got,
                         input logic [BusW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BusW-1:0] mk_frame(input logic [Width-1:0] ch0);
        logic [BusW-1:0] f;
        for (int i = 0; i < int'(NumCh); i++) f[i*Width +: Width] = ch0 + Width'(i * 7);
        return f;
    endfunction

    task automatic send(input logic [BusW-1:0] f);
        bus.in_valid = 1'b1;
        bus.in_audio = f;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic done(input logic [BusW-1:0] f);
        bus.dsp_done    = 1'b1;
        bus.dsp_outputs = f;
        tick();
        bus.dsp_done = 1'b0;
    endtask

    initial begin
        f1 = mk_frame(24'h123456);  f2 = mk_frame(24'h200000);  f3 = mk_frame(24'h300000);
        f4 = mk_frame(24'h400000);  f5 = mk_frame(24'h500000);  f6 = mk_frame(24'h600000);
        f7 = mk_frame(24'h700000);  f8 = mk_frame(24'h800000);  f9 = mk_frame(24'h900000);
        f10 = mk_frame(24'hA00000); f11 = mk_frame(24'hB00000); f12 = mk_frame(24'hC00000);
        f13 = mk_frame(24'hD00000); f14 = mk_frame(24'hE00000);
        o1 = mk_frame(24'hFEDCBA);  o2 = mk_frame(24'h0A0A0A);  o3 = mk_frame(24'h0B0B0B);
        o4 = mk_frame(24'h0C0C0C);  o5 = mk_frame(24'h0D0D0D);

        bus.in_valid = 1'b0;
        bus.in_audio = '0;
        bus.dsp_done = 1'b0;
        bus.dsp_outputs = '0;
        bus.clear_status = 1'b0;
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_start", bus.dsp_start, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_audio", bus.out_audio, 0);
        check("rst_dsp_inputs", bus.dsp_inputs, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overrun", bus.overrun_count, 0);
        check("rst_timeout", bus.timeout_flag, 0);
        reset_n = 1'b1;
        tick();

        // Basic frame: start one cycle after capture, result held after done.
        send(f1);
        check("t1_inputs", bus.dsp_inputs, f1);
        check("t1_start_early", bus.dsp_start, 0);
        check("t1_busy", bus.busy, 1);
        tick();
        check("t1_start", bus.dsp_start, 1);
        tick();
        check("t1_start_clr", bus.dsp_start, 0);
        ov0 = ov_cnt;
        repeat (97) tick();
        check("t1_no_valid", bus.out_valid, 0);
        done(o1);
        check("t1_valid", bus.out_valid, 1);
        check("t1_out", bus.out_audio, o1);
        check("t1_idle", bus.busy, 0);
        tick();
        check("t1_valid_clr", bus.out_valid, 0);
        check("t1_out_held", bus.out_audio, o1);
        check("t1_one_pulse", BusW'(ov_cnt - ov0), 1);
        check("t1_inputs_held", bus.dsp_inputs, f1);

        // Pending slot and drops during one RUN.
        send(f2);
        tick();
        tick();
        send(f3);
        tick();
        send(f4);
        tick();
        send(f5);
        check("t2_overrun", bus.overrun_count, 2);
        check("t2_inputs_stable", bus.dsp_inputs, f2);
        done(o2);
        check("t2_valid", bus.out_valid, 1);
        check("t2_out", bus.out_audio, o2);
        check("t2_idle", bus.busy, 0);
        send(f6);
        check("t2_pend_launch", bus.dsp_inputs, f3);
        check("t2_pend_busy", bus.busy, 1);
        check("t2_overrun_keep", bus.overrun_count, 2);
        tick();
        check("t2_pend_start", bus.dsp_start, 1);
        tick();
        done(o3);
        check("t2_out3", bus.out_audio, o3);
        tick();
        check("t2_refill_launch", bus.dsp_inputs, f6);
        tick();
        tick();
        done(o4);
        check("t2_out4", bus.out_audio, o4);
        tick();
        check("t2_drained", bus.busy, 0);

        // Watchdog expiry mutes the output and sets the sticky flag.
        send(f7);
        repeat (2000) tick();
        check("t3_pre_valid", bus.out_valid, 0);
        check("t3_pre_busy", bus.busy, 1);
        check("t3_pre_flag", bus.timeout_flag, 0);
        tick();
        check("t3_valid", bus.out_valid, 1);
        check("t3_mute", bus.out_audio, 0);
        check("t3_flag", bus.timeout_flag, 1);
        check("t3_idle", bus.busy, 0);
        bus.clear_status = 1'b1;
        tick();
        bus.clear_status = 1'b0;
        check("t3_clr_flag", bus.timeout_flag, 0);
        check("t3_clr_overrun", bus.overrun_count, 0);

        // Done on the last watchdog cycle wins.
        send(f8);
        repeat (2000) tick();
        check("t4_pre_valid", bus.out_valid, 0);
        done(o5);
        check("t4_valid", bus.out_valid, 1);
        check("t4_out", bus.out_audio, o5);
        check("t4_flag", bus.timeout_flag, 0);

        // Clear-then-increment, reset abort, clean restart, saturation.
        send(f9);
        tick();
        tick();
        send(f10);
        send(f11);
        check("t5_overrun1", bus.overrun_count, 1);
        bus.clear_status = 1'b1;
        send(f12);
        bus.clear_status = 1'b0;
        check("t5_clr_inc", bus.overrun_count, 1);
        ov0 = ov_cnt;
        reset_n = 1'b0;
        tick();
        check("t5_rst_start", bus.dsp_start, 0);
        check("t5_rst_valid", bus.out_valid, 0);
        check("t5_rst_out", bus.out_audio, 0);
        check("t5_rst_inputs", bus.dsp_inputs, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_overrun", bus.overrun_count, 0);
        reset_n = 1'b1;
        repeat (5) tick();
        check("t5_no_pending", bus.busy, 0);
        check("t5_no_valid", BusW'(ov_cnt - ov0), 0);
        send(f13);
        check("t5_restart", bus.dsp_inputs, f13);
        tick();
        check("t5_restart_start", bus.dsp_start, 1);
        bus.in_valid = 1'b1;
        bus.in_audio = f14;
        repeat (67000) tick();
        check("t5_sat", bus.overrun_count, 16'hFFFF);
        bus.in_valid = 1'b0;
        tick();
        check("t5_sat_hold", bus.overrun_count, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
